// File: rtl/cic_decimator.sv
// N-stage CIC (Hogenauer) decimator by R with power-of-two gain normalisation,
// rounding and saturation to a Q(DW-FW).FW output sample with a one-cycle strobe.
module cic_decimator #(
  parameter int IW = 12,
  parameter int DW = 14,
  parameter int FW = 9,
  parameter int R  = 8,
  parameter int N  = 3,
  parameter int M  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in,
  output logic          out_valid,
  output logic [DW-1:0] out
);

  localparam int BG = N * $clog2(R * M);
  localparam int AW = IW + BG;
  localparam int SH = IW - 1 + BG - FW;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);
  localparam longint OMAX_L = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam longint OMIN_L = -(64'sd1 <<< (DW - 1));
  localparam logic signed [AW:0] OMAX = OMAX_L[AW:0];
  localparam logic signed [AW:0] OMIN = OMIN_L[AW:0];
  localparam logic signed [AW:0] RND  = (AW + 1)'(1) << (SH - 1);

  if (SH < 1) begin : g_chk_sh
    $error("cic_decimator: SH must be at least 1");
  end
  if ((R < 2) || ((R & (R - 1)) != 0)) begin : g_chk_r
    $error("cic_decimator: R must be a power of two >= 2");
  end
  if ((M != 1) && (M != 2)) begin : g_chk_m
    $error("cic_decimator: M must be 1 or 2");
  end
  if ((N < 1) || (N > 6)) begin : g_chk_n
    $error("cic_decimator: N must be in 1..6");
  end
  if ((AW + 1 < DW) || (AW + 1 > 64)) begin : g_chk_w
    $error("cic_decimator: accumulator width out of supported range");
  end

  logic signed [AW-1:0] in_ext;
  logic                 last_accept;
  logic signed [AW-1:0] integ_q [N];
  logic signed [AW-1:0] integ_d [N];
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] dec_q, dec_d;
  logic                 dec_vld_q, dec_vld_d;
  logic signed [AW-1:0] comb_x [N];
  logic                 comb_v [N];
  logic signed [AW-1:0] comb_d [N];
  logic signed [AW-1:0] comb_q [N];
  logic                 comb_vld_q [N];
  logic signed [AW-1:0] dly_q [N][M];
  logic signed [AW:0]   rnd_sum, rnd_shr;
  logic [DW-1:0]        out_d, out_q;
  logic                 out_valid_q;

  assign in_ext      = {{BG{in[IW-1]}}, in};
  assign last_accept = in_valid && (cnt_q == CNT_LAST);

  // Stage k accumulates stage k-1's registered value; wrap modulo 2^AW is intended.
  always_comb begin
    integ_d = integ_q;
    if (in_valid) begin
      integ_d[0] = integ_q[0] + in_ext;
      for (int k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = last_accept ? '0 : cnt_q + 1'b1;
    end
    dec_d     = last_accept ? integ_d[N-1] : dec_q;
    dec_vld_d = last_accept;
  end

  always_comb begin
    comb_x[0] = dec_q;
    comb_v[0] = dec_vld_q;
    for (int k = 1; k < N; k++) begin
      comb_x[k] = comb_q[k-1];
      comb_v[k] = comb_vld_q[k-1];
    end
    for (int k = 0; k < N; k++) begin
      comb_d[k] = comb_x[k] - dly_q[k][M-1];
    end
  end

  // Round half up, then clamp to the signed DW range.
  always_comb begin
    rnd_sum = $signed({comb_q[N-1][AW-1], comb_q[N-1]}) + RND;
    rnd_shr = rnd_sum >>> SH;
    if (rnd_shr > OMAX) begin
      out_d = OMAX[DW-1:0];
    end else if (rnd_shr < OMIN) begin
      out_d = OMIN[DW-1:0];
    end else begin
      out_d = rnd_shr[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k]    <= '0;
        comb_q[k]     <= '0;
        comb_vld_q[k] <= 1'b0;
        for (int j = 0; j < M; j++) begin
          dly_q[k][j] <= '0;
        end
      end
      cnt_q       <= '0;
      dec_q       <= '0;
      dec_vld_q   <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      integ_q   <= integ_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      dec_vld_q <= dec_vld_d;
      for (int k = 0; k < N; k++) begin
        comb_vld_q[k] <= comb_v[k];
        if (comb_v[k]) begin
          comb_q[k]   <= comb_d[k];
          dly_q[k][0] <= comb_x[k];
          for (int j = 1; j < M; j++) begin
            dly_q[k][j] <= dly_q[k][j-1];
          end
        end
      end
      out_valid_q <= comb_vld_q[N-1];
      if (comb_vld_q[N-1]) begin
        out_q <= out_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: reset, DC gain, impulse response, accumulator
// wrap, gapped input timing and asynchronous mid-frame reset.
module tb_cic_decimator;

  localparam int IW  = 12;
  localparam int DW  = 14;
  localparam int FW  = 9;
  localparam int R   = 8;
  localparam int N   = 3;
  localparam int M   = 1;
  localparam int SH  = IW - 1 + N * 3 - FW;
  localparam int LAT = N + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_s = '0;
  logic          out_valid;
  logic [DW-1:0] out_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;

  logic signed [DW-1:0] got_q[$];
  int                   got_t[$];
  int                   acc_t[$];
  int                   hist[$];
  logic signed [DW-1:0] ref_q[$];
  longint               h[64];
  int                   hl;

  cic_decimator #(.IW(IW), .DW(DW), .FW(FW), .R(R), .N(N), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in       (in_s),
    .out_valid(out_valid),
    .out      (out_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      got_q.push_back(out_s);
      got_t.push_back(cyc);
    end
  end

  task automatic clear_logs();
    got_q.delete();
    got_t.delete();
    acc_t.delete();
    hist.delete();
    n_acc = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_s = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic drive(input bit v, input int x);
    @(negedge clk);
    in_valid = v;
    in_s = x[IW-1:0];
    if (v) begin
      hist.push_back(x);
      n_acc++;
      if (n_acc % R == 0) acc_t.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, int'($urandom_range(0, 4095)) - 2048);
  endtask

  // Direct FIR form of the CIC: boxcar^N impulse response, N-1 samples of pipeline skew.
  function automatic int model(input int n);
    longint y = 0;
    int t = R * n - 1;
    for (int j = 0; j < hl; j++) begin
      int idx = t - (N - 1) - j;
      if (idx >= 0 && idx < hist.size()) y += h[j] * longint'(hist[idx]);
    end
    return int'((y + (64'sd1 <<< (SH - 1))) >>> SH);
  endfunction

  task automatic build_h();
    longint tmp[64];
    for (int i = 0; i < 64; i++) h[i] = 0;
    h[0] = 1;
    hl = 1;
    repeat (N) begin
      for (int i = 0; i < 64; i++) tmp[i] = 0;
      for (int i = 0; i < hl; i++)
        for (int j = 0; j < R * M; j++) tmp[i+j] += h[i];
      hl += R * M - 1;
      for (int i = 0; i < 64; i++) h[i] = tmp[i];
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_s !== '0) begin errors++; $display("FAIL reset_out got %0d want 0", out_s); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    in_valid = 1'b1;
    in_s = 12'd1024;
    repeat (20) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_s !== '0) begin
      errors++; $display("FAIL reset_hold got v=%b out=%0d want v=0 out=0", out_valid, out_s);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_dc(input string name, input int x, input int expv);
    apply_reset();
    repeat (8 * R) drive(1'b1, x);
    idle(LAT + 2);
    checks++;
    if (got_q.size() != 8) begin
      errors++; $display("FAIL %s_count got %0d want 8", name, got_q.size());
    end
    if (got_q.size() > 0 && acc_t.size() > 0) begin
      checks++;
      if (got_t[0] - acc_t[0] != LAT) begin
        errors++; $display("FAIL %s_latency got %0d want %0d", name, got_t[0] - acc_t[0], LAT);
      end
    end
    for (int i = 2; i < got_q.size(); i++) begin
      checks++;
      if (int'(got_q[i]) != expv) begin
        errors++; $display("FAIL %s_value[%0d] got %0d want %0d", name, i, got_q[i], expv);
      end
    end
    for (int i = 1; i < got_t.size(); i++) begin
      checks++;
      if (got_t[i] - got_t[i-1] != R) begin
        errors++; $display("FAIL %s_spacing[%0d] got %0d want %0d", name, i, got_t[i] - got_t[i-1], R);
      end
    end
  endtask

  task automatic test_impulse();
    int expv[5] = '{21, 42, 1, 0, 0};
    int sum = 0;
    apply_reset();
    drive(1'b1, 2047);
    repeat (5 * R - 1) drive(1'b1, 0);
    idle(LAT + 2);
    checks++;
    if (got_q.size() != 5) begin
      errors++; $display("FAIL impulse_count got %0d want 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      sum += int'(got_q[i]);
      checks++;
      if (int'(got_q[i]) != expv[i]) begin
        errors++; $display("FAIL impulse_value[%0d] got %0d want %0d", i, got_q[i], expv[i]);
      end
    end
    // Each decimated phase of the impulse response carries 1/R of the DC gain.
    checks++;
    if (sum < 62 || sum > 66) begin
      errors++; $display("FAIL impulse_sum got %0d want 64+-2", sum);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    repeat (512 * R) drive(1'b1, 2047);
    idle(LAT + 2);
    checks++;
    if (got_q.size() != 512) begin
      errors++; $display("FAIL wrap_count got %0d want 512", got_q.size());
    end
    for (int i = 2; i < got_q.size(); i++) begin
      checks++;
      if (int'(got_q[i]) != 512) begin
        errors++; $display("FAIL wrap_value[%0d] got %0d want 512", i, got_q[i]);
      end
    end
  endtask

  task automatic test_gaps();
    int smp[48];
    for (int k = 0; k < 48; k++) smp[k] = int'($urandom_range(0, 4095)) - 2048;
    apply_reset();
    for (int k = 0; k < 48; k++) drive(1'b1, smp[k]);
    idle(LAT + 2);
    checks++;
    if (got_q.size() != 6) begin
      errors++; $display("FAIL cont_count got %0d want 6", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (int'(got_q[i]) != model(i + 1)) begin
        errors++; $display("FAIL cont_value[%0d] got %0d want %0d", i, got_q[i], model(i + 1));
      end
    end
    ref_q = got_q;
    apply_reset();
    for (int k = 0; k < 48; k++) begin
      int gaps = 0;
      while (gaps < 10 && $urandom_range(0, 99) >= 30) begin
        drive(1'b0, int'($urandom_range(0, 4095)) - 2048);
        gaps++;
      end
      drive(1'b1, smp[k]);
    end
    idle(LAT + 2);
    checks++;
    if (got_q.size() != ref_q.size()) begin
      errors++; $display("FAIL gap_count got %0d want %0d", got_q.size(), ref_q.size());
    end
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
      checks++;
      if (got_q[i] !== ref_q[i] || int'(got_q[i]) != model(i + 1)) begin
        errors++; $display("FAIL gap_value[%0d] got %0d want %0d", i, got_q[i], model(i + 1));
      end
    end
    for (int i = 0; i < got_t.size() && i < acc_t.size(); i++) begin
      checks++;
      if (got_t[i] - acc_t[i] != LAT) begin
        errors++; $display("FAIL gap_latency[%0d] got %0d want %0d", i, got_t[i] - acc_t[i], LAT);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3 * R) drive(1'b1, 1024);
    repeat (5) drive(1'b1, 1024);
    @(posedge clk);
    #1;
    checks++;
    if (int'($signed(out_s)) != 256) begin
      errors++; $display("FAIL areset_pre got %0d want 256", $signed(out_s));
    end
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_s !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_now got v=%b out=%0d want v=0 out=0", out_valid, out_s);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    drive(1'b1, 2047);
    repeat (R - 2) drive(1'b1, 0);
    idle(2 * R);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL areset_early got %0d strobes want 0", got_q.size());
    end
    drive(1'b1, 0);
    idle(LAT + 2);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL areset_count got %0d want 1", got_q.size());
    end
    if (got_q.size() > 0 && acc_t.size() > 0) begin
      checks++;
      if (int'(got_q[0]) != 21) begin
        errors++; $display("FAIL areset_value got %0d want 21", got_q[0]);
      end
      checks++;
      if (got_t[0] - acc_t[0] != LAT) begin
        errors++; $display("FAIL areset_latency got %0d want %0d", got_t[0] - acc_t[0], LAT);
      end
    end
  endtask

  initial begin
    build_h();
    test_reset();
    test_dc("dc_half", 1024, 256);
    test_dc("dc_negfs", -2048, -512);
    test_dc("dc_posmax", 2047, 512);
    test_impulse();
    test_wrap();
    test_gaps();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
